// File: rtl/voice_pitch_pkg.sv
// Shared widths, the lookup FSM state type and the default voice count
// for the voice pitch scheduler.
package voice_pitch_pkg;

    localparam int NOTE_W             = 7;
    localparam int INC_W              = 16;
    localparam int DEFAULT_NUM_VOICES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker over N request lines. The grant is the first request at
// or after the pointer. The pointer moves past the grant only when advance is high.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [GW-1:0] grant
);

    logic [GW-1:0] ptr_q;
    logic [GW-1:0] ptr_d;
    logic [GW-1:0] idx;
    logic          found;

    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = GW'((32'(ptr_q) + 32'(i)) % 32'(N));
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (32'(grant) == 32'(N - 1)) ? '0 : GW'(grant + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/voice_pitch_scheduler.sv
// Time-shares one external note-to-increment ROM between NUM_VOICES voices.
// Each lookup takes two cycles. A voice rewritten while its lookup is in flight has that result discarded.
module voice_pitch_scheduler
    import voice_pitch_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int VW         = $clog2(NUM_VOICES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        note_we,
    input  logic [VW-1:0]               note_voice,
    input  logic [NOTE_W-1:0]           note_val,
    output logic [NOTE_W-1:0]           rom_note,
    input  logic [INC_W-1:0]            rom_increment,
    output logic [NUM_VOICES*INC_W-1:0] voice_inc,
    output logic [NUM_VOICES-1:0]       inc_update,
    output logic                        busy
);

    localparam int SW = $clog2(NUM_VOICES);

    state_e                  state_q, state_d;
    logic [NUM_VOICES-1:0]   pending_q, pending_d;
    logic [NUM_VOICES-1:0]   wr_hit;
    logic [NUM_VOICES-1:0]   clr;
    logic [NUM_VOICES-1:0]   inc_update_q, inc_update_d;
    logic [NOTE_W-1:0]       notes_q [NUM_VOICES];
    logic [INC_W-1:0]        inc_q [NUM_VOICES];
    logic [SW-1:0]           sel_q, sel_d;
    logic [SW-1:0]           grant;
    logic [NOTE_W-1:0]       rom_note_q, rom_note_d;
    logic                    abort_q, abort_d;
    logic                    load;
    logic                    capture;

    // Decode the write port; voices at or beyond NUM_VOICES never match.
    always_comb begin
        wr_hit = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            wr_hit[v] = note_we && (32'(note_voice) == 32'(v));
        end
    end

    rr_arbiter #(
        .N  (NUM_VOICES),
        .GW (SW)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (pending_q),
        .advance (load),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        capture    = 1'b0;
        abort_d    = abort_q;
        sel_d      = sel_q;
        rom_note_d = rom_note_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    load    = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = CAPTURE;
                abort_d = abort_q | wr_hit[sel_q];
            end
            CAPTURE: begin
                capture = !abort_q && !wr_hit[sel_q];
                if (|pending_q) begin
                    load    = 1'b1;
                    state_d = LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A write landing on the load edge changes the note after it was read, so that lookup is stale too.
        if (load) begin
            sel_d      = grant;
            rom_note_d = notes_q[grant];
            abort_d    = wr_hit[grant];
        end
    end

    always_comb begin
        clr = '0;
        if (load) begin
            clr[grant] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | wr_hit;
    end

    always_comb begin
        inc_update_d = '0;
        if (capture) begin
            inc_update_d[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            sel_q        <= '0;
            abort_q      <= 1'b0;
            rom_note_q   <= '0;
            inc_update_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                notes_q[v] <= '0;
                inc_q[v]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            sel_q        <= sel_d;
            abort_q      <= abort_d;
            rom_note_q   <= rom_note_d;
            inc_update_q <= inc_update_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr_hit[v]) begin
                    notes_q[v] <= note_val;
                end
            end
            if (capture) begin
                inc_q[sel_q] <= rom_increment;
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_inc
        assign voice_inc[g*INC_W +: INC_W] = inc_q[g];
    end

    assign rom_note   = rom_note_q;
    assign inc_update = inc_update_q;
    assign busy       = (|pending_q) | (state_q != IDLE);

endmodule

// File: tb/tb_voice_pitch_scheduler.sv
// Bench for voice_pitch_scheduler: directed timing scenarios plus a random run
// checked against a last-note-wins model and a registered ROM model.
module tb_voice_pitch_scheduler;

    localparam int NV  = 4;
    localparam int VWB = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            note_we;
    logic [VWB-1:0]  note_voice;
    logic [6:0]      note_val;
    logic [6:0]      rom_note;
    logic [15:0]     rom_increment;
    logic [NV*16-1:0] voice_inc;
    logic [NV-1:0]   inc_update;
    logic            busy;

    int total = 0;
    int bad   = 0;
    logic [6:0] notes_m [NV];

    voice_pitch_scheduler #(
        .NUM_VOICES (NV),
        .VW         (VWB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .note_we       (note_we),
        .note_voice    (note_voice),
        .note_val      (note_val),
        .rom_note      (rom_note),
        .rom_increment (rom_increment),
        .voice_inc     (voice_inc),
        .inc_update    (inc_update),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // External ROM: increment = note * 512, one registered cycle behind rom_note.
    always @(posedge clk) rom_increment <= {rom_note, 9'b0};

    function automatic logic [15:0] inc_of(logic [6:0] n);
        return {n, 9'b0};
    endfunction

    function automatic logic [15:0] vinc(int v);
        return voice_inc[16*v +: 16];
    endfunction

    task automatic tick();
        if (note_we && !reset && (note_voice < VWB'(NV))) notes_m[note_voice[1:0]] = note_val;
        @(posedge clk);
        #1;
        note_we = 1'b0;
    endtask

    task automatic wr(int v, int n);
        note_we    = 1'b1;
        note_voice = VWB'(v);
        note_val   = 7'(n);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        note_we = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int v = 0; v < NV; v++) notes_m[v] = 7'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr(0, 99);
        tick();
        tick();
        reset = 1'b0;
        for (int v = 0; v < NV; v++) notes_m[v] = 7'd0;
        total++; if (rom_note !== 7'd0) begin bad++; $display("FAIL reset_rom_note got=%0d exp=0", rom_note); end
        total++; if (voice_inc !== '0) begin bad++; $display("FAIL reset_voice_inc got=%h exp=0", voice_inc); end
        total++; if (inc_update !== 4'b0) begin bad++; $display("FAIL reset_inc_update got=%b exp=0000", inc_update); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        wr(0, 69);
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_t got=%b exp=1", busy); end
        tick();
        total++; if (rom_note !== 7'd69) begin bad++; $display("FAIL single_rom_note got=%0d exp=69", rom_note); end
        total++; if (inc_update !== 4'b0) begin bad++; $display("FAIL single_early_pulse got=%b exp=0000", inc_update); end
        tick();
        total++; if (inc_update !== 4'b0) begin bad++; $display("FAIL single_early_pulse2 got=%b exp=0000", inc_update); end
        tick();
        total++; if (vinc(0) !== 16'h8A00) begin bad++; $display("FAIL single_inc got=%h exp=8a00", vinc(0)); end
        total++; if (inc_update !== 4'b0001) begin bad++; $display("FAIL single_pulse got=%b exp=0001", inc_update); end
        tick();
        total++; if (inc_update !== 4'b0) begin bad++; $display("FAIL single_pulse_end got=%b exp=0000", inc_update); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_burst();
        logic [6:0]  nl [4];
        logic [15:0] ev [4];
        logic [3:0]  e;
        nl = '{7'd0, 7'd60, 7'd69, 7'd127};
        ev = '{16'h0000, 16'h7800, 16'h8A00, 16'hFE00};
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c < 4) wr(c, int'(nl[c]));
            tick();
            e = 4'b0;
            if (c >= 3 && c <= 9 && ((c - 3) % 2) == 0) e = 4'(1 << ((c - 3) / 2));
            total++; if (inc_update !== e) begin bad++; $display("FAIL burst_pulse c=%0d got=%b exp=%b", c, inc_update, e); end
        end
        for (int v = 0; v < NV; v++) begin
            total++; if (vinc(v) !== ev[v]) begin bad++; $display("FAIL burst_value v=%0d got=%h exp=%h", v, vinc(v), ev[v]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_retrigger();
        logic [3:0] e;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c == 0) wr(2, 60);
            if (c == 2) wr(2, 69);
            tick();
            e = (c == 5) ? 4'b0100 : 4'b0000;
            total++; if (inc_update !== e) begin bad++; $display("FAIL retrig_pulse c=%0d got=%b exp=%b", c, inc_update, e); end
        end
        total++; if (vinc(2) !== 16'h8A00) begin bad++; $display("FAIL retrig_value got=%h exp=8a00", vinc(2)); end
    endtask

    task automatic test_fairness();
        int cnt [NV];
        int rw;
        int win;
        bit started;
        for (int v = 0; v < NV; v++) cnt[v] = 0;
        rw = -1;
        win = 0;
        started = 1'b0;
        do_reset();
        for (int i = 0; i < 100 && win < 40; i++) begin
            if (i < 4) wr(i, int'($urandom_range(0, 127)));
            else if (rw >= 0) wr(rw, int'($urandom_range(0, 127)));
            rw = -1;
            tick();
            for (int v = 0; v < NV; v++) begin
                if (inc_update[v]) begin
                    rw = v;
                    started = 1'b1;
                    total++; if (vinc(v) !== inc_of(notes_m[v])) begin bad++; $display("FAIL fair_value v=%0d got=%h exp=%h", v, vinc(v), inc_of(notes_m[v])); end
                    if (win < 40) cnt[v]++;
                end
            end
            if (started) win++;
        end
        for (int v = 0; v < NV; v++) begin
            total++; if (cnt[v] !== 5) begin bad++; $display("FAIL fair_count v=%0d got=%0d exp=5", v, cnt[v]); end
        end
    endtask

    task automatic test_reset_capture();
        do_reset();
        wr(1, 50);
        tick();
        tick();
        tick();
        total++; if (inc_update !== 4'b0) begin bad++; $display("FAIL rstcap_pre got=%b exp=0000", inc_update); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int v = 0; v < NV; v++) notes_m[v] = 7'd0;
        total++; if (inc_update !== 4'b0) begin bad++; $display("FAIL rstcap_pulse got=%b exp=0000", inc_update); end
        total++; if (voice_inc !== '0) begin bad++; $display("FAIL rstcap_inc got=%h exp=0", voice_inc); end
        total++; if (rom_note !== 7'd0) begin bad++; $display("FAIL rstcap_rom got=%0d exp=0", rom_note); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstcap_busy got=%b exp=0", busy); end
        tick();
        total++; if (inc_update !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstcap_after got=%b/%b exp=0000/0", inc_update, busy); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        wr(5, 100);
        tick();
        for (int c = 0; c < 4; c++) begin
            total++; if (busy !== 1'b0 || inc_update !== 4'b0) begin bad++; $display("FAIL oor_busy c=%0d got=%b/%b exp=0/0000", c, busy, inc_update); end
            tick();
        end
        total++; if (voice_inc !== '0) begin bad++; $display("FAIL oor_inc got=%h exp=0", voice_inc); end
    endtask

    task automatic test_random();
        int waited;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 35) wr(int'($urandom_range(0, 5)), int'($urandom_range(0, 127)));
            tick();
            for (int v = 0; v < NV; v++) begin
                if (inc_update[v]) begin
                    total++; if (vinc(v) !== inc_of(notes_m[v])) begin bad++; $display("FAIL rand_pulse v=%0d got=%h exp=%h", v, vinc(v), inc_of(notes_m[v])); end
                end
            end
        end
        waited = 0;
        while (busy === 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_drain got=busy exp=idle within 100 cycles"); end
        for (int v = 0; v < NV; v++) begin
            total++; if (vinc(v) !== inc_of(notes_m[v])) begin bad++; $display("FAIL rand_final v=%0d got=%h exp=%h", v, vinc(v), inc_of(notes_m[v])); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        note_we    = 1'b0;
        note_voice = '0;
        note_val   = '0;
        for (int v = 0; v < NV; v++) notes_m[v] = 7'd0;
        test_reset();
        test_single();
        test_burst();
        test_retrigger();
        test_fairness();
        test_reset_capture();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
